breakout_game_ctrl: RTL and testbench

Game-flow sequencer for the breakout display. It sits between `pong_graph`, which supplies the `hit`/`miss` pulses and consumes the freeze and ball-reset controls, and the text/seven-segment path, which consumes score, lives and state. It owns the IDLE/SERVE/PLAY/OVER/WIN state machine, the serve and game-over delay timers, the 4-digit BCD score, the lives counter and the remaining-brick count.

---
 rtl/breakout_game_ctrl.sv | 163 ++++++++++++++++
 tb/tb_breakout_game_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/breakout_game_ctrl.sv
// Breakout game-flow sequencer: IDLE/SERVE/PLAY/OVER/WIN FSM, delay timers, BCD score, lives and bricks.
// Optional high-score register enabled by defining BREAKOUT_GAME_CTRL_HISCORE_EN.
module breakout_game_ctrl #(
  parameter int LIVES       = 3,
  parameter int BRICKS      = 40,
  parameter int SERVE_TICKS = 120,
  parameter int OVER_TICKS  = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        start,
  input  logic        pause,
  input  logic        hit,
  input  logic        miss,
  output logic [2:0]  state,
  output logic        gra_still,
  output logic        ball_reset,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [7:0]  bricks_left,
  output logic [15:0] hi_score
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_OVER  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  localparam logic [2:0] LIVES_INIT  = 3'(LIVES);
  localparam logic [7:0] BRICKS_INIT = 8'(BRICKS);
  localparam logic [7:0] SERVE_LAST  = 8'(SERVE_TICKS - 1);
  localparam logic [7:0] OVER_T      = 8'(OVER_TICKS);

  state_t     st;
  logic [7:0] timer;
  logic       start_ok;

  assign state = st;

  // BCD increment with per-digit carry, saturating at 9999
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[i*4 +: 4] == 4'd9) begin
            r[i*4 +: 4] = 4'd0;
          end else begin
            r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    start_ok = 1'b0;
    if (start) begin
      if (st == S_IDLE)
        start_ok = 1'b1;
      else if ((st == S_OVER || st == S_WIN) && timer == OVER_T)
        start_ok = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st          <= S_IDLE;
      timer       <= '0;
      score       <= '0;
      lives       <= LIVES_INIT;
      bricks_left <= BRICKS_INIT;
      gra_still   <= 1'b1;
      ball_reset  <= 1'b0;
    end else begin
      ball_reset <= 1'b0;
      gra_still  <= 1'b1;
      if (start_ok) begin
        st          <= S_SERVE;
        timer       <= '0;
        score       <= '0;
        lives       <= LIVES_INIT;
        bricks_left <= BRICKS_INIT;
        ball_reset  <= 1'b1;
      end else begin
        case (st)
          S_SERVE: begin
            if (frame_tick) begin
              if (timer == SERVE_LAST) begin
                st        <= S_PLAY;
                timer     <= '0;
                gra_still <= pause;
              end else begin
                timer <= timer + 8'd1;
              end
            end
          end
          S_PLAY: begin
            // A hit that clears the last brick wins outright and masks a coincident miss
            if (hit && bricks_left == 8'd1) begin
              score       <= bcd_inc(score);
              bricks_left <= '0;
              st          <= S_WIN;
              timer       <= '0;
            end else begin
              if (hit) begin
                score <= bcd_inc(score);
                if (bricks_left != 8'd0)
                  bricks_left <= bricks_left - 8'd1;
              end
              if (miss) begin
                if (lives != 3'd0)
                  lives <= lives - 3'd1;
                timer <= '0;
                if (lives <= 3'd1) begin
                  st <= S_OVER;
                end else begin
                  st         <= S_SERVE;
                  ball_reset <= 1'b1;
                end
              end else begin
                gra_still <= pause;
              end
            end
          end
          S_OVER, S_WIN: begin
            if (frame_tick && timer != OVER_T)
              timer <= timer + 8'd1;
          end
          default: ;
        endcase
      end
    end
  end

`ifdef BREAKOUT_GAME_CTRL_HISCORE_EN
  state_t st_q;

  // BCD digits are ordered, so a plain binary compare is a BCD magnitude compare
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= S_IDLE;
      hi_score <= '0;
    end else begin
      st_q <= st;
      if ((st == S_OVER || st == S_WIN) && st_q == S_PLAY && score > hi_score)
        hi_score <= score;
    end
  end
`else
  assign hi_score = 16'h0000;
`endif

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed self-checking bench for breakout_game_ctrl (default and a 2-brick short-timer instance).
module tb_breakout_game_ctrl;

  logic clk = 1'b0;
  logic reset, frame_tick, start, pause, hit, miss;

  logic [2:0]  state, lives, state2, lives2;
  logic        gra_still, ball_reset, gra_still2, ball_reset2;
  logic [15:0] score, hi_score, score2, hi_score2;
  logic [7:0]  bricks_left, bricks_left2;

  int checks = 0;
  int errors = 0;

`ifdef BREAKOUT_GAME_CTRL_HISCORE_EN
  localparam logic [15:0] HI_G1 = 16'h0012;
  localparam logic [15:0] HI_W2 = 16'h0002;
`else
  localparam logic [15:0] HI_G1 = 16'h0000;
  localparam logic [15:0] HI_W2 = 16'h0000;
`endif

  always #5 clk = ~clk;

  breakout_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause),
    .hit(hit), .miss(miss), .state(state), .gra_still(gra_still), .ball_reset(ball_reset),
    .score(score), .lives(lives), .bricks_left(bricks_left), .hi_score(hi_score)
  );

  breakout_game_ctrl #(.LIVES(3), .BRICKS(2), .SERVE_TICKS(2), .OVER_TICKS(3)) dut2 (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start), .pause(pause),
    .hit(hit), .miss(miss), .state(state2), .gra_still(gra_still2), .ball_reset(ball_reset2),
    .score(score2), .lives(lives2), .bricks_left(bricks_left2), .hi_score(hi_score2)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
    end
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (score !== 16'h0) begin errors++; $display("FAIL reset_score got %h want 0000", score); end
    checks++; if (lives !== 3'd3) begin errors++; $display("FAIL reset_lives got %0d want 3", lives); end
    checks++; if (bricks_left !== 8'd40) begin errors++; $display("FAIL reset_bricks got %0d want 40", bricks_left); end
    checks++; if (gra_still !== 1'b1 || ball_reset !== 1'b0) begin errors++; $display("FAIL reset_ctrl got still=%b br=%b want 1 0", gra_still, ball_reset); end
    checks++; if (hi_score !== 16'h0) begin errors++; $display("FAIL reset_hi got %h want 0000", hi_score); end
  endtask

  task automatic test_serve();
    start = 1'b1;
    cyc();
    start = 1'b0;
    checks++; if (state !== 3'd1 || ball_reset !== 1'b1) begin errors++; $display("FAIL serve_entry got st=%0d br=%b want 1 1", state, ball_reset); end
    cyc();
    checks++; if (state !== 3'd1 || ball_reset !== 1'b0 || gra_still !== 1'b1) begin errors++; $display("FAIL serve_hold got st=%0d br=%b still=%b want 1 0 1", state, ball_reset, gra_still); end
    hit = 1'b1; miss = 1'b1;
    cyc();
    hit = 1'b0; miss = 1'b0;
    checks++; if (score !== 16'h0 || lives !== 3'd3 || state !== 3'd1) begin errors++; $display("FAIL serve_ignore got sc=%h lv=%0d st=%0d want 0000 3 1", score, lives, state); end
    ticks(119);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_119 got %0d want 1", state); end
    ticks(1);
    checks++; if (state !== 3'd2 || gra_still !== 1'b0) begin errors++; $display("FAIL serve_to_play got st=%0d still=%b want 2 0", state, gra_still); end
  endtask

  task automatic test_score();
    hit = 1'b1;
    repeat (9) cyc();
    hit = 1'b0;
    checks++; if (score !== 16'h0009 || bricks_left !== 8'd31) begin errors++; $display("FAIL score_9 got sc=%h br=%0d want 0009 31", score, bricks_left); end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    checks++; if (score !== 16'h0010 || bricks_left !== 8'd30) begin errors++; $display("FAIL score_carry got sc=%h br=%0d want 0010 30", score, bricks_left); end
  endtask

  task automatic test_pause();
    pause = 1'b1;
    cyc();
    checks++; if (gra_still !== 1'b1 || state !== 3'd2) begin errors++; $display("FAIL pause_freeze got still=%b st=%0d want 1 2", gra_still, state); end
    hit = 1'b1;
    cyc();
    hit = 1'b0;
    checks++; if (score !== 16'h0011 || bricks_left !== 8'd29) begin errors++; $display("FAIL pause_hit got sc=%h br=%0d want 0011 29", score, bricks_left); end
    pause = 1'b0;
    cyc();
    checks++; if (gra_still !== 1'b0) begin errors++; $display("FAIL unpause got still=%b want 0", gra_still); end
  endtask

  task automatic test_miss_over();
    miss = 1'b1; cyc(); miss = 1'b0;
    checks++; if (lives !== 3'd2 || state !== 3'd1 || ball_reset !== 1'b1) begin errors++; $display("FAIL miss1 got lv=%0d st=%0d br=%b want 2 1 1", lives, state, ball_reset); end
    ticks(120);
    miss = 1'b1; cyc(); miss = 1'b0;
    checks++; if (lives !== 3'd1 || state !== 3'd1) begin errors++; $display("FAIL miss2 got lv=%0d st=%0d want 1 1", lives, state); end
    ticks(120);
    hit = 1'b1; cyc(); hit = 1'b0;
    miss = 1'b1; cyc(); miss = 1'b0;
    checks++; if (lives !== 3'd0 || state !== 3'd3 || score !== 16'h0012) begin errors++; $display("FAIL miss3 got lv=%0d st=%0d sc=%h want 0 3 0012", lives, state, score); end
    checks++; if (hi_score !== 16'h0) begin errors++; $display("FAIL hi_entry got %h want 0000", hi_score); end
    cyc();
    checks++; if (hi_score !== HI_G1) begin errors++; $display("FAIL hi_load got %h want %h", hi_score, HI_G1); end
    ticks(179);
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (state !== 3'd3) begin errors++; $display("FAIL over_early_start got %0d want 3", state); end
    ticks(1);
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (state !== 3'd1 || score !== 16'h0 || lives !== 3'd3 || bricks_left !== 8'd40) begin errors++; $display("FAIL over_restart got st=%0d sc=%h lv=%0d br=%0d want 1 0000 3 40", state, score, lives, bricks_left); end
  endtask

  task automatic test_hiscore_keep();
    ticks(120);
    hit = 1'b1; repeat (7) cyc(); hit = 1'b0;
    miss = 1'b1; cyc(); miss = 1'b0;
    ticks(120);
    miss = 1'b1; cyc(); miss = 1'b0;
    ticks(120);
    miss = 1'b1; cyc(); miss = 1'b0;
    cyc();
    checks++; if (state !== 3'd3 || score !== 16'h0007 || hi_score !== HI_G1) begin errors++; $display("FAIL hi_keep got st=%0d sc=%h hi=%h want 3 0007 %h", state, score, hi_score, HI_G1); end
  endtask

  task automatic test_reset_mid();
    ticks(180);
    start = 1'b1; cyc(); start = 1'b0;
    ticks(120);
    hit = 1'b1; cyc(); hit = 1'b0;
    checks++; if (state !== 3'd2 || score !== 16'h0001) begin errors++; $display("FAIL pre_reset got st=%0d sc=%h want 2 0001", state, score); end
    reset = 1'b1; hit = 1'b1; start = 1'b1;
    cyc();
    reset = 1'b0; hit = 1'b0; start = 1'b0;
    checks++; if (state !== 3'd0 || score !== 16'h0 || lives !== 3'd3 || bricks_left !== 8'd40 || gra_still !== 1'b1 || ball_reset !== 1'b0 || hi_score !== 16'h0) begin
      errors++; $display("FAIL reset_mid got st=%0d sc=%h lv=%0d br=%0d still=%b brst=%b hi=%h", state, score, lives, bricks_left, gra_still, ball_reset, hi_score);
    end
  endtask

  task automatic test_win();
    reset = 1'b1; cyc(); reset = 1'b0;
    start = 1'b1; frame_tick = 1'b1; cyc(); start = 1'b0; frame_tick = 1'b0;
    ticks(1);
    checks++; if (state2 !== 3'd1) begin errors++; $display("FAIL win_serve got %0d want 1", state2); end
    ticks(1);
    checks++; if (state2 !== 3'd2) begin errors++; $display("FAIL win_play got %0d want 2", state2); end
    hit = 1'b1; cyc(); hit = 1'b0;
    checks++; if (bricks_left2 !== 8'd1 || score2 !== 16'h0001) begin errors++; $display("FAIL win_hit1 got br=%0d sc=%h want 1 0001", bricks_left2, score2); end
    hit = 1'b1; miss = 1'b1; cyc(); hit = 1'b0; miss = 1'b0;
    checks++; if (state2 !== 3'd4 || lives2 !== 3'd3 || bricks_left2 !== 8'd0 || score2 !== 16'h0002) begin
      errors++; $display("FAIL win_hit_miss got st=%0d lv=%0d br=%0d sc=%h want 4 3 0 0002", state2, lives2, bricks_left2, score2);
    end
    cyc();
    checks++; if (hi_score2 !== HI_W2) begin errors++; $display("FAIL win_hi got %h want %h", hi_score2, HI_W2); end
    ticks(2);
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (state2 !== 3'd4) begin errors++; $display("FAIL win_early_start got %0d want 4", state2); end
    ticks(1);
    start = 1'b1; cyc(); start = 1'b0;
    checks++; if (state2 !== 3'd1 || bricks_left2 !== 8'd2 || score2 !== 16'h0 || ball_reset2 !== 1'b1) begin
      errors++; $display("FAIL win_restart got st=%0d br=%0d sc=%h brst=%b want 1 2 0000 1", state2, bricks_left2, score2, ball_reset2);
    end
  endtask

  initial begin
    reset = 1'b0; frame_tick = 1'b0; start = 1'b0; pause = 1'b0; hit = 1'b0; miss = 1'b0;
    #2;
    test_reset();
    test_serve();
    test_score();
    test_pause();
    test_miss_over();
    test_hiscore_keep();
    test_reset_mid();
    test_win();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
